// File: rtl/upload_controller.sv
// Upload sequencer: filters host bytes down to BF opcodes, writes them to program RAM, terminates on '!'.
// Optional bracket-balance checking is compiled in with `define BRACKET_CHECK_EN.
module upload_controller #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              bracket_err,
    output logic [ADDR_W:0]   prog_len,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_TERM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Last word is reserved for the terminator, so this is the first address that is "full".
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    // Handshake: a byte is consumed on any rising edge where rx_valid and rx_ready are both high.
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_len;
    logic              r_rx_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;

    logic w_is_op;
    logic w_is_end;
    logic w_full;

    function automatic logic f_is_op(input logic [DATA_W-1:0] b);
        case (b)
            DATA_W'(8'h2B), DATA_W'(8'h2D), DATA_W'(8'h3C), DATA_W'(8'h3E),
            DATA_W'(8'h5B), DATA_W'(8'h5D), DATA_W'(8'h2E), DATA_W'(8'h2C): f_is_op = 1'b1;
            default: f_is_op = 1'b0;
        endcase
    endfunction

    assign w_is_op  = f_is_op(rx_data);
    assign w_is_end = (rx_data == DATA_W'(8'h21));
    assign w_full   = (r_ptr == LAST_ADDR);

`ifdef BRACKET_CHECK_EN
    logic [ADDR_W:0] r_depth;
    logic            r_bracket_err;
    logic            w_is_close;
    assign w_is_close = (rx_data == DATA_W'(8'h5D));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_len       <= '0;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef BRACKET_CHECK_EN
            r_depth       <= '0;
            r_bracket_err <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (abort) begin
                r_state    <= S_IDLE;
                r_rx_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
`ifdef BRACKET_CHECK_EN
                r_bracket_err <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start) begin
                            r_state    <= S_RECV;
                            r_ptr      <= '0;
                            r_len      <= '0;
                            r_rx_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_overflow <= 1'b0;
`ifdef BRACKET_CHECK_EN
                            r_depth       <= '0;
                            r_bracket_err <= 1'b0;
`endif
                        end
                    end
                    S_RECV: begin
                        if (rx_valid) begin
                            if (w_is_end) begin
`ifdef BRACKET_CHECK_EN
                                if (r_depth != '0) begin
                                    r_state       <= S_ERR;
                                    r_bracket_err <= 1'b1;
                                    r_rx_ready    <= 1'b0;
                                    r_busy        <= 1'b0;
                                end else
`endif
                                begin
                                    r_state     <= S_TERM;
                                    r_mem_we    <= 1'b1;
                                    r_mem_addr  <= r_ptr;
                                    r_mem_wdata <= '0;
                                    r_rx_ready  <= 1'b0;
                                end
                            end else if (w_is_op) begin
                                if (w_full) begin
                                    r_state    <= S_ERR;
                                    r_overflow <= 1'b1;
                                    r_rx_ready <= 1'b0;
                                    r_busy     <= 1'b0;
                                end
`ifdef BRACKET_CHECK_EN
                                else if (w_is_close && (r_depth == '0)) begin
                                    r_state       <= S_ERR;
                                    r_bracket_err <= 1'b1;
                                    r_rx_ready    <= 1'b0;
                                    r_busy        <= 1'b0;
                                end
`endif
                                else begin
                                    r_state     <= S_WRITE;
                                    r_mem_we    <= 1'b1;
                                    r_mem_addr  <= r_ptr;
                                    r_mem_wdata <= rx_data;
                                    r_rx_ready  <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        r_state    <= S_RECV;
                        r_ptr      <= r_ptr + ADDR_W'(1);
                        r_len      <= r_len + (ADDR_W+1)'(1);
                        r_rx_ready <= 1'b1;
`ifdef BRACKET_CHECK_EN
                        // Depth follows what was actually written, hence updated from the latched byte.
                        if (r_mem_wdata == DATA_W'(8'h5B))
                            r_depth <= r_depth + (ADDR_W+1)'(1);
                        else if (r_mem_wdata == DATA_W'(8'h5D))
                            r_depth <= r_depth - (ADDR_W+1)'(1);
`endif
                    end
                    S_TERM: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Abort kills a write that is already on the bus in the same cycle.
    assign mem_we    = r_mem_we & ~abort;
    assign rx_ready  = r_rx_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign prog_len  = r_len;
    assign dbg_state = r_state;
`ifdef BRACKET_CHECK_EN
    assign bracket_err = r_bracket_err;
`else
    assign bracket_err = 1'b0;
`endif

endmodule
